iceboard_tx_arbiter: RTL and testbench
======================================

Name: iceboard_tx_arbiter

Overview:
- Frame-locked round-robin arbiter that shares the single iceboard control UART transmit byte stream between NUM_REQ requesters, e.g. the SPI bridge command path and local status generators.
- Holds the grant for a whole frame and inserts a programmable idle gap between frames so the iceboard can delimit them.
- Aborts frames whose owner stalls too long, so one dead requester cannot lock the link.
- Sits between the requester logic and the UART byte transmitter inside vidor_sys.

Parameters:
- NUM_REQ, 4: number of requesters (2..16).
- DATA_W, 8: byte width of the data path.
- GAP_CYCLES, 16: idle clock cycles between frames; 0 means no gap.
- TIMEOUT_CYCLES, 1024: consecutive cycles without req_valid from the owner mid-frame before the frame is aborted (>=1).

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ  marks the final byte of a frame; qualified by req_valid.
- req_ready  out  NUM_REQ  per-requester byte accepted.
- tx_valid  out  1  byte valid toward the UART transmitter.
- tx_data  out  DATA_W  byte toward the UART transmitter.
- tx_ready  in  1  UART transmitter can accept a byte.
- grant  out  NUM_REQ  one-hot current owner; all zero when no frame is in progress.
- busy  out  1  high in BUSY or GAP state.
- timeout_err  out  1  one-cycle pulse when a frame is aborted.
- err_id  out  $clog2(NUM_REQ)  index of the last aborted requester; held until the next abort.

Behaviour:
- States: IDLE, BUSY, GAP. Reset values: state=IDLE, grant=0, rr_ptr=NUM_REQ-1 (requester 0 wins first), gap_cnt=0, to_cnt=0, timeout_err=0, err_id=0. Derived outputs at reset: busy=0, tx_valid=0, req_ready=0.
- IDLE, any req_valid=1:
  - Pick the first valid index strictly after rr_ptr, wrapping.
  - Register grant=onehot(winner) and rr_ptr=winner; go to BUSY.
  - Latency is 1 cycle from valid to grant.
  - With no valid requester, stay in IDLE.
- BUSY data path (combinational):
  - tx_valid = req_valid[g]; tx_data = req_data[g].
  - req_ready[i] = tx_ready & grant[i]. All non-owners see req_ready=0.
  - Transfer = tx_valid & tx_ready.
- BUSY transitions:
  - Transfer with req_last[g]=1: grant<=0; go to GAP with gap_cnt<=GAP_CYCLES, or straight to IDLE if GAP_CYCLES=0.
  - Timeout counter to_cnt clears on every transfer and increments on each cycle with req_valid[g]=0.
  - Downstream backpressure (tx_ready=0 while valid) never counts toward timeout.
  - When to_cnt reaches TIMEOUT_CYCLES-1 and req_valid[g] is still 0: pulse timeout_err=1 for one cycle, set err_id=g, set grant<=0, and go to GAP.
  - The aborted frame is not resumed. Its remaining bytes arrive later as a new frame.
- GAP:
  - gap_cnt decrements each cycle; go to IDLE when it reaches 1 (exactly GAP_CYCLES idle cycles).
  - tx_valid=0 throughout.
  - Requests in GAP are ignored until IDLE.
- No interleaving: bytes from different requesters never mix inside a frame.
- Reset asserted mid-frame: all registers return to reset values on the next edge; the partial frame is dropped, with no error pulse.
- tx_data is unconstrained when tx_valid=0. The implementation drives 0.

Decomposition:
- Package iceboard_pkg holds:
  - state enum (IDLE, BUSY, GAP);
  - REQ_IDX_W=$clog2(NUM_REQ) helper;
  - default constants for GAP_CYCLES and TIMEOUT_CYCLES.
- One sub-module, rr_pick: a combinational round-robin picker with inputs req vector and rr_ptr, and outputs one-hot winner, index and any. It is implemented as a rotate, priority-encode, un-rotate sequence.
- Counters and the FSM stay in the top module.

Test Plan:
All scenarios use NUM_REQ=4, GAP_CYCLES=4 and TIMEOUT_CYCLES=8.
1. After reset, req2 sends 0xA1, 0xA2, 0xA3(last) with tx_ready=1 -> grant=0100 one cycle after valid; tx_data shows A1, A2, A3 on 3 consecutive cycles; grant=0 after A3; busy stays 1 for 4 cycles, then 0.
2. All four requesters hold single-byte frames (0x10..0x13, last=1) continuously -> service order 0, 1, 2, 3, 0 with 4 gap cycles between frames.
3. Mid-frame, tx_ready=0 for 20 cycles -> tx_data stable, req_ready[owner]=0, no timeout_err; frame completes when tx_ready returns.
4. req1 sends one byte, then drops valid for 8 cycles -> timeout_err pulses exactly once, err_id=1, grant=0000, then GAP; a pending req3 gets grant=1000 after the gap.
5. req0 and req3 both request while req2 owns the frame -> req_ready[0]=req_ready[3]=0 until req2's last byte; next grant goes to 1000 (req3, after pointer 2), then req0.
6. reset_reset pulsed while req1 is mid-frame -> next cycle grant=0, tx_valid=0, busy=0, timeout_err=0; with req1 and req0 both valid afterward, req0 is granted first.

Source files
------------

// File: rtl/iceboard_pkg.sv
// Shared types and defaults for the iceboard UART transmit arbiter.
package iceboard_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      GAP
   } state_t;

   localparam int DEFAULT_GAP_CYCLES     = 16;
   localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

   function automatic int req_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/iceboard_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after rr_ptr, wrapping.
module rr_pick
   import iceboard_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = req_idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic [IDX_W-1:0]   index,
   output logic               any
);

   logic [2*NUM_REQ-1:0] doubled;
   logic [NUM_REQ-1:0]   rotated;
   logic [IDX_W-1:0]     rot_idx;
   int                   start;

   // Rotate so the slot after rr_ptr lands at bit 0, priority-encode, then rotate the index back.
   always_comb begin
      start = int'(rr_ptr) + 1;
      if (start >= NUM_REQ) start = 0;
      doubled = {req, req} >> start;
      rotated = doubled[NUM_REQ-1:0];
      any     = |req;
      rot_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rotated[i]) rot_idx = IDX_W'(i);
      end
      index  = IDX_W'((int'(rot_idx) + start) % NUM_REQ);
      winner = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         winner[i] = any && (int'(index) == i);
      end
   end

endmodule

// File: rtl/iceboard_tx_arbiter.sv
// Frame-locked round-robin arbiter sharing the iceboard UART byte stream,
// with an inter-frame idle gap and stalled-owner abort.
module iceboard_tx_arbiter
   import iceboard_pkg::*;
#(
   parameter  int NUM_REQ        = 4,
   parameter  int DATA_W         = 8,
   parameter  int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
   parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   localparam int REQ_IDX_W      = req_idx_w(NUM_REQ)
) (
   input  logic                      clk_clk,
   input  logic                      reset_reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      tx_valid,
   output logic [DATA_W-1:0]         tx_data,
   input  logic                      tx_ready,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      busy,
   output logic                      timeout_err,
   output logic [REQ_IDX_W-1:0]      err_id
);

   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   state_t               state;
   logic [REQ_IDX_W-1:0] rr_ptr;
   logic [GAP_W-1:0]     gap_cnt;
   logic [TO_W-1:0]      to_cnt;

   logic [NUM_REQ-1:0]   pick_winner;
   logic [REQ_IDX_W-1:0] pick_index;
   logic                 pick_any;
   logic                 owner_valid;
   logic                 owner_last;
   logic                 transfer;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req    (req_valid),
      .rr_ptr (rr_ptr),
      .winner (pick_winner),
      .index  (pick_index),
      .any    (pick_any)
   );

   // rr_ptr always holds the current owner's index while a frame is in progress.
   assign owner_valid = req_valid[rr_ptr];
   assign owner_last  = req_last[rr_ptr];
   assign busy        = (state != IDLE);
   assign tx_valid    = (state == BUSY) && owner_valid;
   assign tx_data     = tx_valid ? req_data[int'(rr_ptr)*DATA_W +: DATA_W] : '0;
   assign req_ready   = grant & {NUM_REQ{tx_ready}};
   assign transfer    = tx_valid && tx_ready;

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state       <= IDLE;
         grant       <= '0;
         rr_ptr      <= REQ_IDX_W'(NUM_REQ - 1);
         gap_cnt     <= '0;
         to_cnt      <= '0;
         timeout_err <= 1'b0;
         err_id      <= '0;
      end else begin
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  grant  <= pick_winner;
                  rr_ptr <= pick_index;
                  to_cnt <= '0;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               if (transfer) begin
                  to_cnt <= '0;
                  if (owner_last) begin
                     grant <= '0;
                     if (GAP_CYCLES == 0) begin
                        state <= IDLE;
                     end else begin
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP;
                     end
                  end
               // Backpressure with valid held leaves to_cnt untouched.
               end else if (!owner_valid) begin
                  if (to_cnt == TO_LAST) begin
                     timeout_err <= 1'b1;
                     err_id      <= rr_ptr;
                     grant       <= '0;
                     to_cnt      <= '0;
                     if (GAP_CYCLES == 0) begin
                        state <= IDLE;
                     end else begin
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP;
                     end
                  end else begin
                     to_cnt <= to_cnt + TO_W'(1);
                  end
               end
            end
            GAP: begin
               if (gap_cnt <= GAP_W'(1)) begin
                  gap_cnt <= '0;
                  state   <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iceboard_tx_arbiter.sv
// Directed self-checking bench for iceboard_tx_arbiter (4 requesters, gap 4, timeout 8).
module tb_iceboard_tx_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 8;
   localparam int GAP_C   = 4;
   localparam int TO_C    = 8;

   logic                      clk_clk = 1'b0;
   logic                      reset_reset;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_last;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      tx_valid;
   logic [DATA_W-1:0]         tx_data;
   logic                      tx_ready;
   logic [NUM_REQ-1:0]        grant;
   logic                      busy;
   logic                      timeout_err;
   logic [1:0]                err_id;

   int total = 0;
   int bad   = 0;

   iceboard_tx_arbiter #(
      .NUM_REQ        (NUM_REQ),
      .DATA_W         (DATA_W),
      .GAP_CYCLES     (GAP_C),
      .TIMEOUT_CYCLES (TO_C)
   ) dut (
      .clk_clk     (clk_clk),
      .reset_reset (reset_reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .grant       (grant),
      .busy        (busy),
      .timeout_err (timeout_err),
      .err_id      (err_id)
   );

   always #5 clk_clk = ~clk_clk;

   task automatic tick();
      @(posedge clk_clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_req(input int k, input logic v, input logic [7:0] d, input logic l);
      req_valid[k] = v;
      req_data[k*DATA_W +: DATA_W] = d;
      req_last[k] = l;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset_reset = 1'b1;
      req_valid   = '0;
      req_data    = '0;
      req_last    = '0;
      tx_ready    = 1'b0;
      tick();
      tick();
      settle();
      check("rst grant", 32'(grant), 'h0);
      check("rst busy", 32'(busy), 'h0);
      check("rst tx_valid", 32'(tx_valid), 'h0);
      check("rst req_ready", 32'(req_ready), 'h0);
      check("rst timeout_err", 32'(timeout_err), 'h0);
      check("rst err_id", 32'(err_id), 'h0);
      reset_reset = 1'b0;
      tick();

      // Scenario 1: three-byte frame from requester 2, then a 4-cycle gap.
      tx_ready = 1'b1;
      set_req(2, 1'b1, 8'hA1, 1'b0);
      settle();
      check("s1 grant before", 32'(grant), 'h0);
      tick();
      settle();
      check("s1 grant", 32'(grant), 'b0100);
      check("s1 A1", 32'(tx_data), 'hA1);
      check("s1 req_ready", 32'(req_ready), 'b0100);
      tick();
      set_req(2, 1'b1, 8'hA2, 1'b0);
      settle();
      check("s1 A2", 32'(tx_data), 'hA2);
      tick();
      set_req(2, 1'b1, 8'hA3, 1'b1);
      settle();
      check("s1 A3", 32'(tx_data), 'hA3);
      tick();
      set_req(2, 1'b0, 8'h00, 1'b0);
      settle();
      check("s1 grant after", 32'(grant), 'h0);
      check("s1 gap busy 1", 32'(busy), 'h1);
      check("s1 gap tx_valid", 32'(tx_valid), 'h0);
      for (int i = 2; i <= 4; i++) begin
         tick();
         check($sformatf("s1 gap busy %0d", i), 32'(busy), 'h1);
      end
      tick();
      check("s1 idle busy", 32'(busy), 'h0);

      // Scenario 2: all four hold single-byte frames; pointer restarted by reset.
      reset_reset = 1'b1;
      tick();
      reset_reset = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) set_req(k, 1'b1, 8'(8'h10 + k), 1'b1);
      for (int k = 0; k < 5; k++) begin
         tick();
         settle();
         check($sformatf("s2 grant %0d", k), 32'(grant), 32'(1) << (k % 4));
         check($sformatf("s2 data %0d", k), 32'(tx_data), 32'('h10 + (k % 4)));
         tick();
         check($sformatf("s2 gap grant %0d", k), 32'(grant), 'h0);
         check($sformatf("s2 gap ready %0d", k), 32'(req_ready), 'h0);
         repeat (3) tick();
         check($sformatf("s2 gap busy %0d", k), 32'(busy), 'h1);
         tick();
         check($sformatf("s2 idle busy %0d", k), 32'(busy), 'h0);
      end
      req_valid = '0;
      req_last  = '0;

      // Scenario 3: downstream stall mid-frame from requester 1.
      set_req(1, 1'b1, 8'h54, 1'b0);
      tick();
      settle();
      check("s3 grant", 32'(grant), 'b0010);
      check("s3 first byte", 32'(tx_data), 'h54);
      tick();
      set_req(1, 1'b1, 8'h55, 1'b1);
      tx_ready = 1'b0;
      settle();
      check("s3 stall valid", 32'(tx_valid), 'h1);
      check("s3 stall ready", 32'(req_ready), 'h0);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (tx_data !== 8'h55 || req_ready !== 4'b0000 || timeout_err !== 1'b0 || grant !== 4'b0010)
            check($sformatf("s3 stall cycle %0d", i),
                  {8'h0, 4'(grant), 3'h0, timeout_err, 4'(req_ready), tx_data},
                  {8'h0, 4'b0010, 3'h0, 1'b0, 4'b0000, 8'h55});
         else
            total++;
      end
      tx_ready = 1'b1;
      settle();
      check("s3 resume ready", 32'(req_ready), 'b0010);
      tick();
      set_req(1, 1'b0, 8'h00, 1'b0);
      settle();
      check("s3 done grant", 32'(grant), 'h0);
      check("s3 no timeout", 32'(timeout_err), 'h0);
      repeat (4) tick();
      check("s3 idle busy", 32'(busy), 'h0);

      // Scenario 4: requester 1 stalls after one byte while requester 3 waits.
      set_req(1, 1'b1, 8'h77, 1'b0);
      tick();
      settle();
      check("s4 grant", 32'(grant), 'b0010);
      tick();
      set_req(1, 1'b0, 8'h00, 1'b0);
      set_req(3, 1'b1, 8'h33, 1'b1);
      for (int i = 1; i <= 7; i++) begin
         tick();
         check($sformatf("s4 wait %0d", i), {30'h0, timeout_err, grant[1]}, 32'b01);
      end
      tick();
      check("s4 timeout_err", 32'(timeout_err), 'h1);
      check("s4 err_id", 32'(err_id), 'h1);
      check("s4 grant aborted", 32'(grant), 'h0);
      check("s4 busy in gap", 32'(busy), 'h1);
      tick();
      check("s4 pulse once", 32'(timeout_err), 'h0);
      check("s4 err_id held", 32'(err_id), 'h1);
      check("s4 gap ignores req3", 32'(grant), 'h0);
      repeat (2) tick();
      tick();
      check("s4 idle grant", 32'(grant), 'h0);
      tick();
      check("s4 req3 grant", 32'(grant), 'b1000);
      check("s4 req3 data", 32'(tx_data), 'h33);
      tick();
      set_req(3, 1'b0, 8'h00, 1'b0);
      repeat (4) tick();
      check("s4 idle busy", 32'(busy), 'h0);

      // Scenario 5: req0 and req3 wait behind requester 2's frame.
      set_req(2, 1'b1, 8'hC1, 1'b0);
      tick();
      set_req(0, 1'b1, 8'h0A, 1'b1);
      set_req(3, 1'b1, 8'h3B, 1'b1);
      settle();
      check("s5 grant", 32'(grant), 'b0100);
      check("s5 ready first", 32'(req_ready), 'b0100);
      check("s5 data C1", 32'(tx_data), 'hC1);
      tick();
      set_req(2, 1'b1, 8'hC2, 1'b1);
      settle();
      check("s5 ready last", 32'(req_ready), 'b0100);
      check("s5 data C2", 32'(tx_data), 'hC2);
      tick();
      set_req(2, 1'b0, 8'h00, 1'b0);
      repeat (4) tick();
      tick();
      check("s5 next grant req3", 32'(grant), 'b1000);
      check("s5 req3 data", 32'(tx_data), 'h3B);
      tick();
      set_req(3, 1'b0, 8'h00, 1'b0);
      repeat (4) tick();
      tick();
      check("s5 then req0", 32'(grant), 'b0001);
      check("s5 req0 data", 32'(tx_data), 'h0A);
      tick();
      set_req(0, 1'b0, 8'h00, 1'b0);
      repeat (4) tick();
      check("s5 idle busy", 32'(busy), 'h0);

      // Scenario 6: reset while requester 1 is mid-frame.
      set_req(1, 1'b1, 8'h91, 1'b0);
      tick();
      settle();
      check("s6 grant", 32'(grant), 'b0010);
      tick();
      reset_reset = 1'b1;
      tick();
      check("s6 rst grant", 32'(grant), 'h0);
      check("s6 rst tx_valid", 32'(tx_valid), 'h0);
      check("s6 rst busy", 32'(busy), 'h0);
      check("s6 rst timeout_err", 32'(timeout_err), 'h0);
      check("s6 rst err_id", 32'(err_id), 'h0);
      reset_reset = 1'b0;
      set_req(0, 1'b1, 8'h01, 1'b1);
      tick();
      settle();
      check("s6 req0 first", 32'(grant), 'b0001);
      check("s6 req0 data", 32'(tx_data), 'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
